video_dram_arb: RTL and testbench
=================================

// Module: video_dram_arb
// PURPOSE
//  Shares the video DRAM slot between four requesters:
//    - graphics fetch (burst)
//    - tile-map fetch
//    - TS renderer
//    - Z80 (read/write)
//  On every slot strobe it picks one owner and drives the DRAM address/request.
//  It returns per-requester pre_next/next strobes.
//  Sits between video_top's fetch/TS engines and the DRAM controller.
// PARAMETERS
//  DATA_LAT  2  clk cycles from dram_req to rdata valid (next strobe); allowed range 1..4
//  STARVE    3  consecutive TS wins with Z80 pending before Z80 is forced (ts_lp=0 only)
// PORTS
//  clk         in   1   system clock; single clock domain
//  res         in   1   reset, asynchronous, active-high
//  slot_stb    in   1   a DRAM slot is available this cycle (one clk wide)
//  vid_go      in   1   start graphics burst
//  vid_addr    in   21  graphics burst start word address
//  vid_bw      in   5   graphics burst length minus 1 (1..32 words)
//  tm_req      in   1   tile-map word request (level)
//  tm_addr     in   21  tile-map word address
//  ts_req      in   1   TS renderer word request (level)
//  ts_addr     in   21  TS word address
//  ts_lp       in   1   1: TS ranks below Z80 (tsconf[4])
//  cpu_req     in   1   Z80 word request (level)
//  cpu_addr    in   21  Z80 word address
//  cpu_rnw     in   1   Z80 1=read 0=write
//  dram_req    out  1   slot issued this cycle
//  dram_addr   out  21  address of issued slot
//  dram_rnw    out  1   read/write of issued slot (1 unless the Z80 writes)
//  vid_busy    out  1   graphics burst in progress
//  {vid,tm,ts,cpu}_pre_next  out 1 each  owner strobe, coincident with dram_req
//  {vid,tm,ts,cpu}_next      out 1 each  data-valid strobe, DATA_LAT clk after dram_req
// BEHAVIOUR
//  Reset (async): all outputs 0, dram_rnw=1, burst counter=0, starve counter=0, tag pipe cleared.
//  Arbitration happens only on cycles with slot_stb=1.
//    - Result is registered: dram_req/addr/rnw and the owner pre_next appear 1 clk later, for exactly 1 clk.
//    - No eligible requester: dram_req=0 and all pre_next=0.
//  Burst FSM states:
//    - IDLE -> BURST: on a slot with vid_go=1. Load cnt=vid_bw+1 and ptr=vid_addr. The first word is issued on that same slot.
//    - BURST: every slot goes to video. Issue ptr, then ptr+1 (21-bit wrap, 1FFFFF->000000), cnt-1.
//    - BURST -> IDLE: after the slot where cnt reaches 0.
//    - vid_go while in BURST: ignored.
//    - vid_go without slot_stb: not latched. The requester holds vid_go until the first vid_pre_next.
//    - vid_busy=1 from the first issued word through the last issued word.
//  Priority when not bursting: vid_go > tm > {ts, cpu}.
//    - ts_lp=0: ts > cpu, except when the starve counter equals STARVE and cpu_req=1; then cpu wins.
//    - ts_lp=1: cpu > ts.
//    - Starve counter: +1 on each TS win while cpu_req=1; cleared on any cpu win or when cpu_req=0; saturates at STARVE.
//  Request handshake:
//    - Requests are levels sampled at slot_stb.
//    - A requester must drop or update req/addr in the clk after its pre_next; otherwise it is served again on the next slot.
//    - Slots never issue the same request twice: the next slot is at least 2 clk later.
//  Data return:
//    - A DATA_LAT-deep owner-tag shift register generates exactly one *_next per issued read, DATA_LAT clk after its dram_req.
//    - Z80 writes produce cpu_next too; it marks completion.
//    - Tags are shifted every clk regardless of slot_stb.
//  Reset mid-burst: the burst is aborted and in-flight next strobes are dropped.
//  Simultaneous requests: slot_stb together with res=1 issues nothing.
// TESTING
//  1. Burst: vid_go, vid_bw=3, vid_addr=0x1FFFFE, slots every 4 clk
//     -> addrs 1FFFFE, 1FFFFF, 000000, 000001; vid_busy 4 slots; 4 vid_next at +DATA_LAT.
//  2. Contention: tm_req, ts_req, cpu_req all held, ts_lp=0
//     -> tm wins every slot; after tm drops: ts, ts, ts, cpu, ts...
//  3. ts_lp=1 with ts_req and cpu_req held -> cpu wins until cpu_req drops, then ts.
//  4. vid_go and tm_req asserted on the same slot -> vid first; tm is served on the first slot after the burst ends.
//  5. cpu write (cpu_rnw=0, addr 0x00ABCD) -> dram_rnw=0, dram_addr=00ABCD; cpu_next at +DATA_LAT.
//  6. Assert res after the 2nd of 8 burst words -> all outputs 0 at once; no further vid_next; next slot is served by tm.

Source files
------------

// File: rtl/video_dram_arb.sv
// video_dram_arb: shares the video DRAM slot between graphics burst, tile-map, TS renderer and Z80
module video_dram_arb #(
    parameter int DATA_LAT = 2,
    parameter int STARVE   = 3
) (
    input  logic        clk,
    input  logic        res,
    input  logic        slot_stb,
    input  logic        vid_go,
    input  logic [20:0] vid_addr,
    input  logic [4:0]  vid_bw,
    input  logic        tm_req,
    input  logic [20:0] tm_addr,
    input  logic        ts_req,
    input  logic [20:0] ts_addr,
    input  logic        ts_lp,
    input  logic        cpu_req,
    input  logic [20:0] cpu_addr,
    input  logic        cpu_rnw,
    output logic        dram_req,
    output logic [20:0] dram_addr,
    output logic        dram_rnw,
    output logic        vid_busy,
    output logic        vid_pre_next,
    output logic        tm_pre_next,
    output logic        ts_pre_next,
    output logic        cpu_pre_next,
    output logic        vid_next,
    output logic        tm_next,
    output logic        ts_next,
    output logic        cpu_next
);
    localparam int SW = $clog2(STARVE + 1);
    localparam logic [3:0] OWN_VID = 4'b1000;
    localparam logic [3:0] OWN_TM  = 4'b0100;
    localparam logic [3:0] OWN_TS  = 4'b0010;
    localparam logic [3:0] OWN_CPU = 4'b0001;

    typedef enum logic {IDLE, BURST} state_t;

    state_t                     state_q, state_d;
    logic [4:0]                 cnt_q, cnt_d;
    logic [20:0]                ptr_q, ptr_d;
    logic [SW-1:0]              starve_q, starve_d;
    logic                       dram_req_q, dram_req_d;
    logic [20:0]                dram_addr_q, dram_addr_d;
    logic                       dram_rnw_q, dram_rnw_d;
    logic                       vid_busy_q, vid_busy_d;
    logic [3:0]                 pre_q, pre_d;
    logic [DATA_LAT-1:0][3:0]   tag_q, tag_d;
    logic                       cpu_win;

    // Slot arbitration: burst continuation first, then vid_go > tm > ts/cpu with Z80 anti-starvation
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ptr_d       = ptr_q;
        starve_d    = starve_q;
        pre_d       = '0;
        dram_addr_d = '0;
        dram_rnw_d  = 1'b1;
        vid_busy_d  = vid_busy_q && state_q == BURST;
        cpu_win     = cpu_req && (ts_lp || !ts_req || starve_q == SW'(STARVE));
        if (slot_stb) begin
            if (state_q == BURST) begin
                pre_d       = OWN_VID;
                dram_addr_d = ptr_q;
                ptr_d       = ptr_q + 21'd1;
                cnt_d       = cnt_q - 5'd1;
                state_d     = cnt_q == 5'd1 ? IDLE : BURST;
                vid_busy_d  = 1'b1;
            end else if (vid_go) begin
                pre_d       = OWN_VID;
                dram_addr_d = vid_addr;
                ptr_d       = vid_addr + 21'd1;
                cnt_d       = vid_bw;
                state_d     = vid_bw != 5'd0 ? BURST : IDLE;
                vid_busy_d  = 1'b1;
            end else if (tm_req) begin
                pre_d       = OWN_TM;
                dram_addr_d = tm_addr;
            end else if (cpu_win) begin
                pre_d       = OWN_CPU;
                dram_addr_d = cpu_addr;
                dram_rnw_d  = cpu_rnw;
            end else if (ts_req) begin
                pre_d       = OWN_TS;
                dram_addr_d = ts_addr;
            end
            starve_d = (!cpu_req || pre_d[0]) ? '0 :
                       (pre_d[1] && starve_q != SW'(STARVE)) ? starve_q + SW'(1) : starve_q;
        end
        dram_req_d = |pre_d;
    end

    // Owner-tag pipe: one tag per issued slot, emerging DATA_LAT clk after dram_req
    always_comb begin
        tag_d[0] = pre_q;
        for (int i = 1; i < DATA_LAT; i++) tag_d[i] = tag_q[i-1];
    end

    // State and registered outputs; reset aborts any burst and drops in-flight tags
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            ptr_q       <= '0;
            starve_q    <= '0;
            dram_req_q  <= 1'b0;
            dram_addr_q <= '0;
            dram_rnw_q  <= 1'b1;
            vid_busy_q  <= 1'b0;
            pre_q       <= '0;
            tag_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            starve_q    <= starve_d;
            dram_req_q  <= dram_req_d;
            dram_addr_q <= dram_addr_d;
            dram_rnw_q  <= dram_rnw_d;
            vid_busy_q  <= vid_busy_d;
            pre_q       <= pre_d;
            tag_q       <= tag_d;
        end
    end

    assign dram_req     = dram_req_q;
    assign dram_addr    = dram_addr_q;
    assign dram_rnw     = dram_rnw_q;
    assign vid_busy     = vid_busy_q;
    assign vid_pre_next = pre_q[3];
    assign tm_pre_next  = pre_q[2];
    assign ts_pre_next  = pre_q[1];
    assign cpu_pre_next = pre_q[0];
    assign vid_next     = tag_q[DATA_LAT-1][3];
    assign tm_next      = tag_q[DATA_LAT-1][2];
    assign ts_next      = tag_q[DATA_LAT-1][1];
    assign cpu_next     = tag_q[DATA_LAT-1][0];
endmodule

// File: tb/tb_video_dram_arb.sv
// tb_video_dram_arb: random and directed checks of video_dram_arb against a slot-level reference model
module tb_video_dram_arb;
    localparam int DATA_LAT = 2;
    localparam int STARVE   = 3;

    logic        clk, res, slot_stb, vid_go, tm_req, ts_req, ts_lp, cpu_req, cpu_rnw;
    logic [20:0] vid_addr, tm_addr, ts_addr, cpu_addr;
    logic [4:0]  vid_bw;
    logic        dram_req, dram_rnw, vid_busy;
    logic [20:0] dram_addr;
    logic        vid_pre_next, tm_pre_next, ts_pre_next, cpu_pre_next;
    logic        vid_next, tm_next, ts_next, cpu_next;

    video_dram_arb #(.DATA_LAT(DATA_LAT), .STARVE(STARVE)) dut (
        .clk(clk), .res(res), .slot_stb(slot_stb),
        .vid_go(vid_go), .vid_addr(vid_addr), .vid_bw(vid_bw),
        .tm_req(tm_req), .tm_addr(tm_addr),
        .ts_req(ts_req), .ts_addr(ts_addr), .ts_lp(ts_lp),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_rnw(cpu_rnw),
        .dram_req(dram_req), .dram_addr(dram_addr), .dram_rnw(dram_rnw), .vid_busy(vid_busy),
        .vid_pre_next(vid_pre_next), .tm_pre_next(tm_pre_next),
        .ts_pre_next(ts_pre_next), .cpu_pre_next(cpu_pre_next),
        .vid_next(vid_next), .tm_next(tm_next), .ts_next(ts_next), .cpu_next(cpu_next)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          burst_left = 0;
    int          starve = 0;
    logic [20:0] bptr = '0;
    logic [3:0]  hist [8];
    int          nxt_cnt [4];
    logic [3:0]  obs_pre;
    logic [20:0] obs_addr;
    logic        obs_rnw, obs_busy;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic int pick(input logic [3:0] want, input logic cpu_first);
        int order [4];
        if (cpu_first) order = '{3, 2, 0, 1};
        else order = '{3, 2, 1, 0};
        for (int i = 0; i < 4; i++) if (want[order[i]]) return order[i];
        return -1;
    endfunction

    task automatic step();
        logic [3:0]  own;
        logic [20:0] a;
        logic        rnw;
        int          w;
        own = '0;
        a   = '0;
        rnw = 1'b1;
        if (res) begin
            burst_left = 0;
            starve = 0;
            for (int i = 0; i < 8; i++) hist[i] = '0;
        end else if (slot_stb) begin
            if (burst_left > 0) begin
                own = 4'b1000;
                a = bptr;
                bptr = bptr + 21'd1;
                burst_left--;
            end else begin
                w = pick({vid_go, tm_req, ts_req, cpu_req}, ts_lp || starve == STARVE);
                if (w == 3) begin
                    a = vid_addr;
                    bptr = vid_addr + 21'd1;
                    burst_left = int'(vid_bw);
                end else if (w == 2) a = tm_addr;
                else if (w == 1) a = ts_addr;
                else if (w == 0) begin
                    a = cpu_addr;
                    rnw = cpu_rnw;
                end
                if (w >= 0) own = 4'(1 << w);
            end
            if (!cpu_req || own[0]) starve = 0;
            else if (own[1] && starve < STARVE) starve++;
        end
        @(posedge clk);
        #1;
        cyc++;
        hist[cyc % 8] = own;
        chk("issue", 32'({dram_req, dram_rnw, dram_addr}), 32'({own != 4'd0, rnw, a}));
        chk("pre_next", 32'({vid_pre_next, tm_pre_next, ts_pre_next, cpu_pre_next}), 32'(own));
        chk("next", 32'({vid_next, tm_next, ts_next, cpu_next}), 32'(hist[(cyc + 8 - DATA_LAT) % 8]));
        chk("vid_busy", 32'(vid_busy), 32'(own[3] || burst_left > 0));
        nxt_cnt[3] += int'(vid_next);
        nxt_cnt[2] += int'(tm_next);
        nxt_cnt[1] += int'(ts_next);
        nxt_cnt[0] += int'(cpu_next);
    endtask

    task automatic slot(input int gap);
        slot_stb = 1'b1;
        step();
        slot_stb = 1'b0;
        obs_pre  = {vid_pre_next, tm_pre_next, ts_pre_next, cpu_pre_next};
        obs_addr = dram_addr;
        obs_rnw  = dram_rnw;
        obs_busy = vid_busy;
        repeat (gap - 1) step();
    endtask

    logic [20:0] t1_addr [4];
    logic [3:0]  t2_seq [5];
    int          n0;

    initial begin
        for (int i = 0; i < 8; i++) hist[i] = '0;
        for (int i = 0; i < 4; i++) nxt_cnt[i] = 0;
        t1_addr = '{21'h1FFFFE, 21'h1FFFFF, 21'h000000, 21'h000001};
        t2_seq  = '{4'b0010, 4'b0010, 4'b0010, 4'b0001, 4'b0010};
        res = 1'b1; slot_stb = 1'b0; vid_go = 1'b0; vid_addr = '0; vid_bw = '0;
        tm_req = 1'b0; tm_addr = '0; ts_req = 1'b0; ts_addr = '0; ts_lp = 1'b0;
        cpu_req = 1'b0; cpu_addr = '0; cpu_rnw = 1'b1;
        step();
        step();
        chk("reset_outputs", {dram_req, dram_rnw, dram_addr, vid_busy, vid_pre_next, tm_pre_next,
            ts_pre_next, cpu_pre_next, vid_next, tm_next, ts_next, cpu_next}, 32'h4000_0000);
        res = 1'b0;
        step();

        // burst wrapping across the top of the address space
        vid_go = 1'b1; vid_bw = 5'd3; vid_addr = 21'h1FFFFE;
        n0 = nxt_cnt[3];
        for (int i = 0; i < 4; i++) begin
            slot(4);
            vid_go = 1'b0;
            chk("t1_addr", 32'(obs_addr), 32'(t1_addr[i]));
            chk("t1_busy", 32'(obs_busy), 32'd1);
        end
        step();
        chk("t1_vid_nexts", nxt_cnt[3] - n0, 32'd4);

        // contention: tm dominates, then ts with Z80 forced every STARVE+1 slots
        tm_req = 1'b1; tm_addr = 21'h000111; ts_req = 1'b1; ts_addr = 21'h000222;
        cpu_req = 1'b1; cpu_addr = 21'h000333;
        for (int i = 0; i < 3; i++) begin
            slot(3);
            chk("t2_tm", 32'(obs_pre), 32'h4);
        end
        tm_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            slot(3);
            chk("t2_seq", 32'(obs_pre), 32'(t2_seq[i]));
        end

        // ts_lp=1: Z80 ranks above TS
        ts_lp = 1'b1;
        for (int i = 0; i < 3; i++) begin
            slot(2);
            chk("t3_cpu", 32'(obs_pre), 32'h1);
        end
        cpu_req = 1'b0;
        slot(3);
        chk("t3_ts", 32'(obs_pre), 32'h2);
        ts_req = 1'b0; ts_lp = 1'b0;

        // vid_go and tm_req together: tm waits for the burst to finish
        vid_go = 1'b1; vid_bw = 5'd1; vid_addr = 21'h000100; tm_req = 1'b1; tm_addr = 21'h000200;
        slot(3);
        vid_go = 1'b0;
        chk("t4_first", 32'({obs_pre, obs_addr}), 32'({4'h8, 21'h000100}));
        slot(3);
        chk("t4_second", 32'({obs_pre, obs_addr}), 32'({4'h8, 21'h000101}));
        slot(3);
        chk("t4_tm", 32'({obs_pre, obs_addr}), 32'({4'h4, 21'h000200}));
        tm_req = 1'b0;

        // Z80 write
        cpu_req = 1'b1; cpu_rnw = 1'b0; cpu_addr = 21'h00ABCD;
        slot_stb = 1'b1;
        step();
        slot_stb = 1'b0;
        chk("t5_write", 32'({dram_req, dram_rnw, dram_addr}), 32'({1'b1, 1'b0, 21'h00ABCD}));
        cpu_req = 1'b0; cpu_rnw = 1'b1;
        repeat (DATA_LAT) step();
        chk("t5_cpu_next", 32'(cpu_next), 32'd1);
        repeat (3) step();

        // asynchronous reset in the middle of an 8-word burst
        vid_go = 1'b1; vid_bw = 5'd7; vid_addr = 21'h000040; tm_req = 1'b1; tm_addr = 21'h000300;
        slot(3);
        vid_go = 1'b0;
        slot_stb = 1'b1;
        step();
        slot_stb = 1'b0;
        n0 = nxt_cnt[3];
        #2 res = 1'b1;
        #1 chk("t6_async", {dram_req, dram_rnw, dram_addr, vid_busy, vid_pre_next, tm_pre_next,
            ts_pre_next, cpu_pre_next, vid_next, tm_next, ts_next, cpu_next}, 32'h4000_0000);
        slot_stb = 1'b1;
        step();
        slot_stb = 1'b0;
        step();
        res = 1'b0;
        repeat (4) step();
        chk("t6_no_vid_next", nxt_cnt[3] - n0, 32'd0);
        slot(3);
        chk("t6_tm", 32'({obs_pre, obs_addr}), 32'({4'h4, 21'h000300}));
        tm_req = 1'b0;

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            vid_go   = $urandom_range(0, 9) == 0;
            vid_bw   = 5'($urandom_range(0, 7));
            vid_addr = 21'($urandom);
            tm_req   = $urandom_range(0, 9) < 3;
            tm_addr  = 21'($urandom);
            ts_req   = $urandom_range(0, 9) < 7;
            ts_addr  = 21'($urandom);
            ts_lp    = $urandom_range(0, 3) == 0;
            cpu_req  = $urandom_range(0, 9) < 7;
            cpu_addr = 21'($urandom);
            cpu_rnw  = 1'($urandom);
            slot(int'($urandom_range(2, 5)));
            if ($urandom_range(0, 99) == 0) begin
                res = 1'b1;
                step();
                res = 1'b0;
            end
        end
        repeat (6) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
